// File: rtl/mem_io_responder_if.sv
// ============================================================================
// Module      : mem_io_responder_if
// Description : External CPU bus plus UART TX/RX byte streams and status
//               flags shared between the CPU side and the memory/IO responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    modport master (
        output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
        input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready,
               program_stop, tx_overflow
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
        output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready,
               program_stop, tx_overflow
    );
endinterface

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ============================================================================
// Module      : mem_io_responder
// Description : Byte-wide RAM and I/O responder (UART TX FIFO, RX source,
//               cycle counter, stop flag). Define MEM_IO_RX_EN for the RX path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    input  wire logic          rdy_in,
    mem_io_responder_if.slave  bus
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [17:0]      C_IO_UART   = 18'h30000;
    localparam logic [17:0]      C_IO_CNT    = 18'h30004;
    localparam logic [CNT_W-1:0] C_FULL_LVL  = CNT_W'(TX_DEPTH);
    localparam logic [CNT_W-1:0] C_NEAR_FULL = CNT_W'(TX_DEPTH - 2);

    logic [7:0]       ram_q [0:(1<<ADDR_WIDTH)-1];
    logic [7:0]       fifo_q [0:TX_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      cyc_cnt_q, snap_q;
    logic [7:0]       mem_din_q;
    logic             io_full_q, overflow_q, stop_q;

    logic [17:0] w_addr;
    logic        w_is_io, w_rd, w_wr, w_hit_uart, w_hit_cnt, w_hit_cnt0;
    logic        w_rx_take;
    logic [7:0]  w_rx_byte, w_rd_data, w_push_byte;
    logic        w_push_req, w_push, w_pop, w_full;
    logic        w_unused_bits;

    assign w_addr     = bus.mem_a[17:0];
    assign w_is_io    = (w_addr[17:16] == 2'b11);
    assign w_rd       = rdy_in && !bus.mem_wr;
    assign w_wr       = rdy_in && bus.mem_wr;
    assign w_hit_uart = (w_addr == C_IO_UART);
    assign w_hit_cnt  = (w_addr[17:2] == C_IO_CNT[17:2]);
    assign w_hit_cnt0 = (w_addr == C_IO_CNT);

`ifdef MEM_IO_RX_EN
    assign w_rx_take     = w_rd && w_hit_uart && bus.rx_valid;
    assign w_rx_byte     = bus.rx_data;
    assign w_unused_bits = ^bus.mem_a[31:18];
`else
    assign w_rx_take     = 1'b0;
    assign w_rx_byte     = 8'h00;
    assign w_unused_bits = ^{bus.mem_a[31:18], bus.rx_data, bus.rx_valid};
`endif

    assign bus.rx_ready = w_rx_take;

    // Byte 0 of the counter window reads the live count, the same value it snapshots.
    always_comb begin
        w_rd_data = 8'h00;
        if (!w_is_io) begin
            w_rd_data = ram_q[bus.mem_a[ADDR_WIDTH-1:0]];
        end else if (w_hit_uart) begin
            w_rd_data = w_rx_take ? w_rx_byte : 8'h00;
        end else if (w_hit_cnt) begin
            case (w_addr[1:0])
                2'd0:    w_rd_data = cyc_cnt_q[7:0];
                2'd1:    w_rd_data = snap_q[15:8];
                2'd2:    w_rd_data = snap_q[23:16];
                default: w_rd_data = snap_q[31:24];
            endcase
        end
    end

    assign w_push_req  = w_wr && ((w_hit_uart && (bus.mem_dout != 8'h00)) || w_hit_cnt0);
    assign w_push_byte = w_hit_uart ? bus.mem_dout : 8'h00;
    assign w_full      = (count_q == C_FULL_LVL);
    assign w_pop       = (count_q != '0) && bus.tx_ready;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign count_d     = count_q + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

    always_ff @(posedge clk_in) begin
        if (w_wr && !w_is_io) begin
            ram_q[bus.mem_a[ADDR_WIDTH-1:0]] <= bus.mem_dout;
        end
        if (w_push) begin
            fifo_q[wr_ptr_q] <= w_push_byte;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            io_full_q  <= 1'b0;
            overflow_q <= 1'b0;
            stop_q     <= 1'b0;
            cyc_cnt_q  <= 32'd0;
            snap_q     <= 32'd0;
            mem_din_q  <= 8'h00;
        end else begin
            count_q   <= count_d;
            io_full_q <= (count_d >= C_NEAR_FULL);
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push_req && w_full && !w_pop) begin
                overflow_q <= 1'b1;
            end
            if (w_wr && w_hit_cnt0) begin
                stop_q <= 1'b1;
            end
            if (rdy_in) begin
                cyc_cnt_q <= cyc_cnt_q + 32'd1;
            end
            if (w_rd && w_hit_cnt0) begin
                snap_q <= cyc_cnt_q;
            end
            if (w_rd) begin
                mem_din_q <= w_rd_data;
            end
        end
    end

    assign bus.mem_din        = mem_din_q;
    assign bus.io_buffer_full = io_full_q;
    assign bus.tx_data        = fifo_q[rd_ptr_q];
    assign bus.tx_valid       = (count_q != '0);
    assign bus.program_stop   = stop_q;
    assign bus.tx_overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// ============================================================================
// Module      : tb_mem_io_responder
// Description : Scoreboard bench for mem_io_responder (RAM, TX FIFO, counter,
//               stop flag, RX path, async reset).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_io_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;

    always #5 clk = ~clk;

    mem_io_responder_if bus();

    mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(8)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_rd_q [$];
    logic [7:0]  exp_tx_q [$];
    logic        rd_flag = 1'b0;
    logic        rd_seen;
    logic [31:0] m_cnt, m_snap;
    logic [7:0]  e_rd, e_tx;

`ifdef MEM_IO_RX_EN
    localparam logic [7:0] C_RX_EXP = 8'h37;
    localparam logic       C_RX_RDY = 1'b1;
`else
    localparam logic [7:0] C_RX_EXP = 8'h00;
    localparam logic       C_RX_RDY = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference cycle counter: one tick per edge with rdy high since reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 32'd0;
        else if (rdy) m_cnt <= m_cnt + 32'd1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_seen <= 1'b0;
        else rd_seen <= rd_flag && rdy;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_seen) begin
                if (exp_rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got %0h expected none", bus.mem_din);
                end else begin
                    e_rd = exp_rd_q.pop_front();
                    chk("rd_data", 32'(bus.mem_din), 32'(e_rd));
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected: got %0h expected none", bus.tx_data);
                end else begin
                    e_tx = exp_tx_q.pop_front();
                    chk("tx_data", 32'(bus.tx_data), 32'(e_tx));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_a    = 32'h0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = 8'h00;
        rd_flag      = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_wr   = 1'b1;
        bus.mem_dout = d;
        rd_flag      = 1'b0;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] e);
        bus.mem_a  = a;
        bus.mem_wr = 1'b0;
        rd_flag    = 1'b1;
        exp_rd_q.push_back(e);
        cyc();
        idle();
    endtask

    task automatic rd_counter();
        m_snap = m_cnt;
        rd(32'h30004, m_snap[7:0]);
        rd(32'h30005, m_snap[15:8]);
        rd(32'h30006, m_snap[23:16]);
        rd(32'h30007, m_snap[31:24]);
    endtask

    task automatic push_tx(input logic [7:0] d, input logic accepted);
        if (accepted) exp_tx_q.push_back(d);
        wr(32'h30000, d);
    endtask

    task automatic drain(input string name);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 40 && bus.tx_valid; i++) cyc();
        chk({name, "_empty"}, 32'(bus.tx_valid), 32'd0);
        chk({name, "_left"}, 32'(exp_tx_q.size()), 32'd0);
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rdy          = 1'b1;
        repeat (3) cyc();

        chk("rst_mem_din", 32'(bus.mem_din), 32'd0);
        chk("rst_io_full", 32'(bus.io_buffer_full), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_stop", 32'(bus.program_stop), 32'd0);
        chk("rst_overflow", 32'(bus.tx_overflow), 32'd0);
        rst_n = 1'b1;

        // Counter after 300 active edges
        repeat (300) cyc();
        chk("cnt_model_300", m_cnt, 32'd300);
        rd_counter();

        // RAM write then read, aliasing and the top address
        wr(32'h00010, 8'hA5);
        rd(32'h00010, 8'hA5);
        wr(32'h1FFFF, 8'h3C);
        rd(32'h1FFFF, 8'h3C);
        rd(32'h20010, 8'hA5);
        rd(32'h30008, 8'h00);
        rd(32'h00010, 8'hA5);

        // Freeze: no write, no count, mem_din holds
        rdy = 1'b0;
        wr(32'h00010, 8'h11);
        repeat (49) cyc();
        chk("freeze_din", 32'(bus.mem_din), 32'hA5);
        rdy = 1'b1;
        rd(32'h00010, 8'hA5);
        rd_counter();

        // TX FIFO ordering with zero byte dropped
        push_tx(8'h41, 1'b1);
        push_tx(8'h00, 1'b0);
        push_tx(8'h42, 1'b1);
        chk("tx_valid_held", 32'(bus.tx_valid), 32'd1);
        chk("tx_head", 32'(bus.tx_data), 32'h41);
        drain("tx_simple");

        // Back-pressure, overflow, push+pop at full
        for (int i = 1; i <= 6; i++) begin
            push_tx(8'(8'h50 + i), 1'b1);
            if (i == 5) chk("near_full_5", 32'(bus.io_buffer_full), 32'd0);
        end
        chk("near_full_6", 32'(bus.io_buffer_full), 32'd1);
        push_tx(8'h57, 1'b1);
        push_tx(8'h58, 1'b1);
        chk("ovf_at_8", 32'(bus.tx_overflow), 32'd0);
        push_tx(8'h59, 1'b0);
        chk("ovf_at_9", 32'(bus.tx_overflow), 32'd1);
        bus.tx_ready = 1'b1;
        push_tx(8'h77, 1'b1);
        drain("tx_full");
        chk("ovf_sticky", 32'(bus.tx_overflow), 32'd1);
        chk("near_full_clr", 32'(bus.io_buffer_full), 32'd0);

        // RX read path
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h37;
        bus.mem_a    = 32'h30000;
        bus.mem_wr   = 1'b0;
        rd_flag      = 1'b1;
        exp_rd_q.push_back(C_RX_EXP);
        #1;
        chk("rx_ready", 32'(bus.rx_ready), 32'(C_RX_RDY));
        cyc();
        idle();
        bus.rx_valid = 1'b0;
        rd(32'h30000, 8'h00);
        chk("rx_ready_idle", 32'(bus.rx_ready), 32'd0);

        // Stop flag pushes 0x00 and is sticky
        chk("stop_pre", 32'(bus.program_stop), 32'd0);
        exp_tx_q.push_back(8'h00);
        wr(32'h30004, 8'h99);
        chk("stop_set", 32'(bus.program_stop), 32'd1);
        chk("stop_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("stop_tx_head", 32'(bus.tx_data), 32'h00);
        for (int i = 1; i <= 5; i++) push_tx(8'(8'h60 + i), 1'b1);
        repeat (3) cyc();
        chk("stop_sticky", 32'(bus.program_stop), 32'd1);
        chk("pre_rst_full", 32'(bus.io_buffer_full), 32'd1);

        // Asynchronous reset mid-FIFO
        exp_tx_q.delete();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("arst_stop", 32'(bus.program_stop), 32'd0);
        chk("arst_overflow", 32'(bus.tx_overflow), 32'd0);
        chk("arst_io_full", 32'(bus.io_buffer_full), 32'd0);
        chk("arst_mem_din", 32'(bus.mem_din), 32'd0);
        cyc();
        rst_n = 1'b1;
        rd(32'h00010, 8'hA5);
        rd(32'h1FFFF, 8'h3C);
        repeat (3) cyc();
        chk("rd_queue_left", 32'(exp_rd_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
